// File: rtl/dwc_ddrphy_pmu_acsm_ram_arb.sv
// ACSM instruction RAM arbiter: sequencer fetch port vs host CSR port, one access per DfiClk.
// Optional feature macro DWC_DDRPHY_ACSM_ARB_WRLOCK_EN rejects host writes while the sequencer runs.
module dwc_ddrphy_pmu_acsm_ram_arb #(
  parameter int DATAWID    = 72,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 15,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic               i_DfiClk,
  input  logic               i_Reset,
  input  logic               i_seq_req,
  input  logic [AW-1:0]      i_seq_addr,
  input  logic               i_seq_run,
  output logic               o_seq_gnt,
  output logic               o_seq_rdvld,
  output logic [DATAWID-1:0] o_seq_rddata,
  input  logic               i_host_req,
  input  logic               i_host_wr,
  input  logic [AW-1:0]      i_host_addr,
  input  logic [DATAWID-1:0] i_host_wrdata,
  output logic               o_host_ack,
  output logic               o_host_err,
  output logic               o_host_rdvld,
  output logic [DATAWID-1:0] o_host_rddata,
  output logic               o_ram_ce,
  output logic               o_ram_wr,
  output logic [AW-1:0]      o_ram_addr,
  output logic [DATAWID-1:0] o_ram_wrdata,
  input  logic [DATAWID-1:0] i_ram_rddata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SEQ  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

  logic [7:0] r_starve_cnt;
  logic [7:0] w_starve_nxt;
  owner_t     r_rd_owner;
  owner_t     w_rd_owner_nxt;
  logic       w_force;
  logic       w_host_gnt;
  logic       w_seq_gnt;
  logic       w_reject;

`ifdef DWC_DDRPHY_ACSM_ARB_WRLOCK_EN
  assign w_reject = i_host_wr & i_seq_run;
`else
  logic w_unused_seq_run;
  assign w_unused_seq_run = i_seq_run;
  assign w_reject         = 1'b0;
`endif

  // Sequencer wins contention until the host has waited STARVE_MAX cycles.
  assign w_force    = (r_starve_cnt >= LP_STARVE_MAX);
  assign w_host_gnt = i_host_req & (~i_seq_req | w_force);
  assign w_seq_gnt  = i_seq_req & ~w_host_gnt;

  assign o_seq_gnt    = w_seq_gnt;
  assign o_host_ack   = w_host_gnt;
  assign o_host_err   = w_host_gnt & w_reject;
  assign o_ram_ce     = w_host_gnt | w_seq_gnt;
  assign o_ram_wr     = w_host_gnt & i_host_wr & ~w_reject;
  assign o_ram_addr   = w_host_gnt ? i_host_addr : i_seq_addr;
  assign o_ram_wrdata = i_host_wrdata;

  assign o_seq_rdvld   = (r_rd_owner == OWN_SEQ);
  assign o_host_rdvld  = (r_rd_owner == OWN_HOST);
  assign o_seq_rddata  = i_ram_rddata;
  assign o_host_rddata = i_ram_rddata;

  always_comb begin
    w_starve_nxt   = r_starve_cnt;
    w_rd_owner_nxt = OWN_NONE;
    if (i_host_req && !w_host_gnt) begin
      if (r_starve_cnt != 8'hFF) begin
        w_starve_nxt = r_starve_cnt + 8'd1;
      end
    end else begin
      w_starve_nxt = 8'd0;
    end
    // Rejected host accesses are always writes, so they never tag a read.
    if (w_host_gnt && !i_host_wr) begin
      w_rd_owner_nxt = OWN_HOST;
    end else if (w_seq_gnt) begin
      w_rd_owner_nxt = OWN_SEQ;
    end
  end

  always_ff @(posedge i_DfiClk or posedge i_Reset) begin
    if (i_Reset) begin
      r_starve_cnt <= 8'd0;
      r_rd_owner   <= OWN_NONE;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_rd_owner   <= w_rd_owner_nxt;
    end
  end

endmodule
